psum_col_fifo: RTL and testbench



---
 rtl/corelet_pkg.sv | 10 +
 rtl/psum_fifo_lane.sv | 49 ++++
 rtl/psum_col_fifo.sv | 73 +++++++
 tb/tb_psum_col_fifo.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/corelet_pkg.sv
// Shared corelet dimensions and types for the MAC array output path.
package corelet_pkg;

    localparam int unsigned COL         = 8;
    localparam int unsigned PSUM_BW     = 16;
    localparam int unsigned OFIFO_DEPTH = 64;

    typedef logic [PSUM_BW-1:0] psum_t;

endpackage

// File: rtl/psum_fifo_lane.sv
// One column lane of the psum output FIFO: circular buffer with wrap-bit pointers.
module psum_fifo_lane
    import corelet_pkg::*;
#(
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned DEPTH   = OFIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic [psum_bw-1:0] din,
    input  logic               pop,
    output logic [psum_bw-1:0] head,
    output logic               empty,
    output logic               full,
    output logic               ovf_pulse
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]        wptr_q;
    logic [AW:0]        rptr_q;
    logic [psum_bw-1:0] mem_q [DEPTH];
    logic               wr_en;

    always_comb begin
        empty     = (wptr_q == rptr_q);
        full      = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        // A full lane still accepts a write when the row pop frees the head slot this cycle.
        wr_en     = wr && (!full || pop);
        ovf_pulse = wr && full && !pop;
        head      = mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop)   rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/psum_col_fifo.sv
// Deskew buffer between the MAC array south edge and PMEM: per-column lanes,
// released as complete row-aligned vectors.
module psum_col_fifo
    import corelet_pkg::*;
#(
    parameter int unsigned col     = COL,
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned DEPTH   = OFIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*psum_bw-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   out_strobe,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_ovf
);

    logic [col-1:0]         lane_empty;
    logic [col-1:0]         lane_full;
    logic [col-1:0]         lane_ovf;
    logic [col*psum_bw-1:0] head_row;
    logic                   pop;

    logic [col*psum_bw-1:0] out_q;
    logic                   strobe_q;
    logic                   ovf_q;

    for (genvar c = 0; c < col; c++) begin : g_lane
        psum_fifo_lane #(
            .psum_bw (psum_bw),
            .DEPTH   (DEPTH)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .wr        (wr[c]),
            .din       (in[c*psum_bw +: psum_bw]),
            .pop       (pop),
            .head      (head_row[c*psum_bw +: psum_bw]),
            .empty     (lane_empty[c]),
            .full      (lane_full[c]),
            .ovf_pulse (lane_ovf[c])
        );
    end

    always_comb begin
        o_valid = &(~lane_empty);
        o_full  = |lane_full;
        o_ready = !o_full;
        pop     = rd && o_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q    <= '0;
            strobe_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            strobe_q <= pop;
            if (pop) out_q <= head_row;
            if (|lane_ovf) ovf_q <= 1'b1;
        end
    end

    assign out        = out_q;
    assign out_strobe = strobe_q;
    assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_psum_col_fifo.sv
// Self-checking bench for psum_col_fifo against a per-lane queue model.
module tb_psum_col_fifo;

    localparam int unsigned COLS  = 8;
    localparam int unsigned BW    = 16;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned RW    = COLS * BW;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] in;
    logic [COLS-1:0] wr;
    logic          rd;
    logic [RW-1:0] out;
    logic          out_strobe, o_valid, o_full, o_ready, o_ovf;

    always #5 clk = ~clk;

    psum_col_fifo #(
        .col     (COLS),
        .psum_bw (BW),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .wr         (wr),
        .rd         (rd),
        .out        (out),
        .out_strobe (out_strobe),
        .o_valid    (o_valid),
        .o_full     (o_full),
        .o_ready    (o_ready),
        .o_ovf      (o_ovf)
    );

    // Reference model: one FIFO queue per column, plus expected registered outputs.
    logic [BW-1:0] q [COLS][$];
    logic [RW-1:0] exp_out;
    logic          exp_strobe;
    logic          exp_ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic m_valid();
        for (int c = 0; c < COLS; c++) if (q[c].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_full();
        for (int c = 0; c < COLS; c++) if (q[c].size() == DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int c = 0; c < COLS; c++) r[c*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".out"},        out,                  exp_out);
        check({tag, ".out_strobe"}, RW'(out_strobe),      RW'(exp_strobe));
        check({tag, ".o_valid"},    RW'(o_valid),         RW'(m_valid()));
        check({tag, ".o_full"},     RW'(o_full),          RW'(m_full()));
        check({tag, ".o_ready"},    RW'(o_ready),         RW'(!m_full()));
        check({tag, ".o_ovf"},      RW'(o_ovf),           RW'(exp_ovf));
    endtask

    // Called 1 time unit after a rising edge; applies inputs for one cycle.
    task automatic cycle(input string tag, input logic [COLS-1:0] w, input logic [RW-1:0] d,
                         input logic r);
        logic accept;
        wr = w;
        in = d;
        rd = r;
        accept = r && m_valid();
        @(posedge clk);
        #1;
        exp_strobe = accept;
        if (accept)
            for (int c = 0; c < COLS; c++) exp_out[c*BW +: BW] = q[c].pop_front();
        for (int c = 0; c < COLS; c++) begin
            if (w[c]) begin
                if (q[c].size() < DEPTH) q[c].push_back(d[c*BW +: BW]);
                else exp_ovf = 1'b1;
            end
        end
        wr = '0;
        rd = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        wr    = '0;
        rd    = 1'b0;
        in    = '0;
        reset = 1'b1;
        #1;
        for (int c = 0; c < COLS; c++) q[c].delete();
        exp_out    = '0;
        exp_strobe = 1'b0;
        exp_ovf    = 1'b0;
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_all({tag, ".post"});
    endtask

    initial begin
        logic [RW-1:0]   d;
        logic [COLS-1:0] w;
        int              wcnt [COLS];
        int              guard;

        reset = 1'b0;
        wr    = '0;
        rd    = 1'b0;
        in    = '0;
        #2;
        do_reset("reset");

        // Empty pop: rd with nothing buffered must do nothing.
        for (int i = 0; i < 5; i++) cycle("empty_pop", '0, rand_row(), 1'b1);

        // Skewed fill: lane c starts at cycle c, rows 0..7 valued 0x100*c+r.
        for (int t = 0; t < 15; t++) begin
            w = '0;
            d = '0;
            for (int c = 0; c < COLS; c++) begin
                if (t >= c && t < c + 8) begin
                    w[c]         = 1'b1;
                    d[c*BW +: BW] = BW'(32'h100 * c + (t - c));
                end
            end
            cycle("skew_fill", w, d, 1'b0);
        end
        for (int i = 0; i < 8; i++) cycle("skew_pop", '0, '0, 1'b1);
        cycle("skew_idle", '0, '0, 1'b0);

        // Full / overflow: 64 rows, then one extra on lane 3 only, then drain.
        for (int i = 0; i < DEPTH; i++) cycle("fill", '1, rand_row(), 1'b0);
        cycle("ovf_lane3", COLS'(8'b0000_1000), rand_row(), 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle("drain", '0, '0, 1'b1);
        cycle("drained_pop", '0, '0, 1'b1);

        // Simultaneous write and pop on full lanes.
        do_reset("reset2");
        for (int i = 0; i < DEPTH; i++) cycle("fill2", '1, rand_row(), 1'b0);
        cycle("wr_rd_full", '1, rand_row(), 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle("drain2", '0, '0, 1'b1);
        cycle("drain2_end", '0, '0, 1'b1);

        // Wrap-around: 200 rows per lane, random skew, occupancy kept at most 10.
        for (int c = 0; c < COLS; c++) wcnt[c] = 0;
        guard = 0;
        while (guard < 3000) begin
            logic done;
            done = 1'b1;
            for (int c = 0; c < COLS; c++) if (wcnt[c] < 200) done = 1'b0;
            if (done) break;
            w = '0;
            for (int c = 0; c < COLS; c++) begin
                if (wcnt[c] < 200 && q[c].size() < 10 && $urandom_range(3) != 0) begin
                    w[c] = 1'b1;
                    wcnt[c]++;
                end
            end
            cycle("wrap", w, rand_row(), $urandom_range(1) == 1);
            guard++;
        end
        check("wrap_budget", RW'(guard < 3000), RW'(1));
        guard = 0;
        while (m_valid() && guard < 50) begin
            cycle("wrap_drain", '0, '0, 1'b1);
            guard++;
        end

        // Reset mid-stream with 20 rows buffered.
        do_reset("reset3");
        for (int i = 0; i < 20; i++) cycle("pre_reset", '1, rand_row(), 1'b0);
        @(negedge clk);
        do_reset("mid_reset");
        cycle("aaaa_wr", '1, {COLS{16'hAAAA}}, 1'b0);
        cycle("aaaa_pop", '0, '0, 1'b1);
        check("aaaa_value", out, {COLS{16'hAAAA}});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
